// File: rtl/spdif_pkg.sv
// Shared constants and types for the parametrised S/PDIF transmitter.
// Preambles are listed MSB first, one half-bit per tick.
package spdif_pkg;

    localparam logic [7:0] PRE_X = 8'b1110_0010;
    localparam logic [7:0] PRE_Y = 8'b1110_0100;
    localparam logic [7:0] PRE_Z = 8'b1110_1000;

    localparam int FRAMES_PER_BLOCK   = 192;
    localparam int TICKS_PER_SUBFRAME = 64;

    localparam int AUX_LSB = 4;
    localparam int V_BIT   = 28;
    localparam int U_BIT   = 29;
    localparam int C_BIT   = 30;
    localparam int P_BIT   = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/spdif_sample_fifo.sv
// Sample-pair FIFO with full/empty flags derived from wrap-bit pointers.
// Read data is combinational so a pop and its data land in the same cycle.
module spdif_sample_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spdif_tx_param.sv
// IEC 60958 transmitter: FIFO-fed subframe builder plus BMC line encoder.
// All timing is driven by the half-bit enable; tick 63 of each subframe is the load point.
module spdif_tx_param
    import spdif_pkg::*;
#(
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                bit_en_i,
    input  logic                enable_i,
    input  logic                sample_valid_i,
    output logic                sample_ready_o,
    input  logic [SAMPLE_W-1:0] sample_l_i,
    input  logic [SAMPLE_W-1:0] sample_r_i,
    input  logic [CS_W-1:0]     cs_i,
    output logic                spdif_o,
    output logic                block_start_o,
    output logic                underrun_o
);

    localparam logic [5:0] LAST_TICK  = 6'(TICKS_PER_SUBFRAME - 1);
    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);

    tx_state_e                 state_q, state_d;
    logic [5:0]                tick_q, tick_d;
    logic [7:0]                frame_q, frame_d;
    logic [31:0]               word_q, word_d;
    logic [7:0]                pre_q, pre_d;
    logic [SAMPLE_W-1:0]       hold_r_q, hold_r_d;
    logic                      hold_v_q, hold_v_d;
    logic [CS_W-1:0]           cs_q, cs_d;
    logic                      spdif_q, spdif_d;
    logic                      block_start_q, block_start_d;
    logic                      underrun_q, underrun_d;

    logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [2*SAMPLE_W-1:0]     fifo_rdata;
    logic [SAMPLE_W-1:0]       fifo_l, fifo_r;
    logic                      load, left_load, c_bit;
    logic [CS_W-1:0]           cs_eff;
    logic [FRAMES_PER_BLOCK-1:0] cs_ext;

    function automatic logic [31:0] build_word(input logic [SAMPLE_W-1:0] s,
                                               input logic v, input logic c);
        logic [31:0] w;
        w = '0;
        w[V_BIT-1 -: SAMPLE_W] = s;
        w[V_BIT] = v;
        w[U_BIT] = 1'b0;
        w[C_BIT] = c;
        w[P_BIT] = ^w[C_BIT:AUX_LSB];
        return w;
    endfunction

    spdif_sample_fifo #(.W(2*SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i ({sample_l_i, sample_r_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fifo_push      = sample_valid_i && !fifo_full;
    assign sample_ready_o = !fifo_full;
    assign fifo_l         = fifo_rdata[2*SAMPLE_W-1 -: SAMPLE_W];
    assign fifo_r         = fifo_rdata[SAMPLE_W-1:0];

    // Idle parks tick_q at 63, so every enable pulse in idle is a left load.
    assign load      = bit_en_i && (tick_q == LAST_TICK);
    assign left_load = load && (state_q != ST_LEFT);

    // Frame 0 uses the status word being latched this very cycle.
    assign cs_eff = (left_load && frame_q == 8'd0) ? cs_i : cs_q;
    assign cs_ext = FRAMES_PER_BLOCK'(cs_eff);
    assign c_bit  = cs_ext[frame_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (left_load)  state_d = enable_i ? ST_LEFT : ST_IDLE;
        else if (load)  state_d = ST_RIGHT;
    end

    always_comb begin
        tick_d        = tick_q;
        frame_d       = frame_q;
        word_d        = word_q;
        pre_d         = pre_q;
        hold_r_d      = hold_r_q;
        hold_v_d      = hold_v_q;
        cs_d          = cs_q;
        spdif_d       = spdif_q;
        block_start_d = 1'b0;
        underrun_d    = 1'b0;
        fifo_pop      = 1'b0;
        if (bit_en_i) begin
            if (state_q == ST_IDLE)  spdif_d = 1'b0;
            else if (tick_q < 6'd8)  spdif_d = pre_q[~tick_q[2:0]];
            else if (!tick_q[0])     spdif_d = ~spdif_q;
            else                     spdif_d = spdif_q ^ word_q[tick_q[5:1]];
            tick_d = (state_d == ST_IDLE) ? LAST_TICK : tick_q + 6'd1;
            if (left_load) begin
                if (!enable_i) begin
                    frame_d = 8'd0;
                end else begin
                    fifo_pop   = !fifo_empty;
                    underrun_d = fifo_empty;
                    hold_v_d   = fifo_empty;
                    hold_r_d   = fifo_empty ? '0 : fifo_r;
                    word_d     = build_word(fifo_empty ? '0 : fifo_l, fifo_empty, c_bit);
                    pre_d      = (frame_q == 8'd0) ? PRE_Z : PRE_X;
                    if (frame_q == 8'd0) begin
                        cs_d          = cs_i;
                        block_start_d = 1'b1;
                    end
                end
            end else if (load) begin
                word_d  = build_word(hold_r_q, hold_v_q, c_bit);
                pre_d   = PRE_Y;
                frame_d = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_q        <= LAST_TICK;
            frame_q       <= '0;
            word_q        <= '0;
            pre_q         <= '0;
            hold_r_q      <= '0;
            hold_v_q      <= 1'b0;
            cs_q          <= '0;
            spdif_q       <= 1'b0;
            block_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            frame_q       <= frame_d;
            word_q        <= word_d;
            pre_q         <= pre_d;
            hold_r_q      <= hold_r_d;
            hold_v_q      <= hold_v_d;
            cs_q          <= cs_d;
            spdif_q       <= spdif_d;
            block_start_q <= block_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign spdif_o       = spdif_q;
    assign block_start_o = block_start_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_spdif_tx_param.sv
// Bench for spdif_tx_param: decodes the BMC line back into subframes and
// compares them against a scoreboard of pushed sample pairs and planned underruns.
module tb_spdif_tx_param;

    localparam logic [7:0] TB_X = 8'b1110_0010;
    localparam logic [7:0] TB_Y = 8'b1110_0100;
    localparam logic [7:0] TB_Z = 8'b1110_1000;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        bit_en = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [23:0] sample_l = '0;
    logic [23:0] sample_r = '0;
    logic [31:0] cs_tb = '0;
    logic        sample_ready_o, spdif_o, block_start_o, underrun_o;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    spdif_tx_param dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .bit_en_i       (bit_en),
        .enable_i       (enable),
        .sample_valid_i (sample_valid),
        .sample_ready_o (sample_ready_o),
        .sample_l_i     (sample_l),
        .sample_r_i     (sample_r),
        .cs_i           (cs_tb),
        .spdif_o        (spdif_o),
        .block_start_o  (block_start_o),
        .underrun_o     (underrun_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] build(input logic [23:0] s, input logic v, input logic c);
        logic [31:0] w;
        w = '0;
        w[27:4] = s;
        w[28]   = v;
        w[30]   = c;
        w[31]   = ^w[30:4];
        return w;
    endfunction

    // ---------------- line decoder / scoreboard consumer ----------------
    logic        tick_seen = 1'b0;
    logic [63:0] hb;
    int          cnt = 0, frm = 0, bs_cnt = 0, ur_cnt = 0;
    int          hi_cnt = 0, n_sub = 0, bs_total = 0, ur_total = 0;
    bit          sub_r = 1'b0;
    exp_t        cur_e;
    logic [31:0] last_wl, last_wr;

    always @(posedge clk) tick_seen <= bit_en;

    always @(negedge clk) begin
        logic [7:0]  pre;
        logic [31:0] w, ew;
        logic        c;
        int          bv;
        if (!rst_ni) begin
            cnt = 0; frm = 0; sub_r = 1'b0; bs_cnt = 0; ur_cnt = 0;
            hi_cnt = 0; n_sub = 0; bs_total = 0; ur_total = 0;
        end else begin
            if (block_start_o) begin bs_cnt++; bs_total++; end
            if (underrun_o)    begin ur_cnt++; ur_total++; end
            if (tick_seen) begin
                if (spdif_o) hi_cnt++;
                if (cnt == 0 && !spdif_o) begin
                    frm = 0;
                    sub_r = 1'b0;
                end else begin
                    hb[cnt] = spdif_o;
                    cnt++;
                    if (cnt == 64) begin
                        cnt = 0;
                        n_sub++;
                        for (int i = 0; i < 8; i++) pre[7-i] = hb[i];
                        w = '0;
                        bv = 0;
                        for (int k = 4; k < 32; k++) begin
                            w[k] = hb[2*k] ^ hb[2*k+1];
                            if (hb[2*k] == hb[2*k-1]) bv++;
                        end
                        c = (frm < 32) ? cs_tb[frm] : 1'b0;
                        if (!sub_r) begin
                            if (sb_q.size() == 0) begin
                                chk("sb_empty", 32'd0, 32'd1);
                                cur_e = '0;
                            end else begin
                                cur_e = sb_q.pop_front();
                            end
                            ew = build(cur_e.l, cur_e.v, c);
                            last_wl = w;
                            chk("pre_L", {24'd0, pre}, {24'd0, (frm == 0) ? TB_Z : TB_X});
                            chk("word_L", w, ew);
                            chk("bmc_L", bv, 0);
                            chk("block_start", bs_cnt, (frm == 0) ? 1 : 0);
                            chk("underrun", ur_cnt, {31'd0, cur_e.v});
                            bs_cnt = 0;
                            ur_cnt = 0;
                            sub_r = 1'b1;
                        end else begin
                            ew = build(cur_e.r, cur_e.v, c);
                            last_wr = w;
                            chk("pre_R", {24'd0, pre}, {24'd0, TB_Y});
                            chk("word_R", w, ew);
                            chk("bmc_R", bv, 0);
                            sub_r = 1'b0;
                            frm = (frm == 191) ? 0 : frm + 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk) bit_en = 1'b1;
        @(negedge clk) bit_en = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r, input int bound);
        bit   acc;
        exp_t e;
        @(negedge clk);
        sample_l = l;
        sample_r = r;
        sample_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (sample_ready_o) begin
                acc = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("push_accept", {31'd0, acc}, 32'd1);
        if (acc) begin
            e.l = l; e.r = r; e.v = 1'b0;
            sb_q.push_back(e);
        end
    endtask

    task automatic push_underrun();
        exp_t e;
        e = '0;
        e.v = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        bit_en = 1'b0;
        sample_valid = 1'b0;
        enable = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_hi;

        // Reset values, then idle with data waiting: nothing popped, line stays low.
        do_reset();
        chk("rst_spdif", {31'd0, spdif_o}, 32'd0);
        chk("rst_ready", {31'd0, sample_ready_o}, 32'd1);
        chk("rst_block_start", {31'd0, block_start_o}, 32'd0);
        chk("rst_underrun", {31'd0, underrun_o}, 32'd0);
        for (int i = 0; i < 4; i++) push_pair(24'(i + 7), 24'(i + 9), 5);
        run_ticks(200);
        chk("idle_line_high", hi_cnt, 0);
        chk("idle_subframes", n_sub, 0);
        chk("idle_no_pop", {31'd0, sample_ready_o}, 32'd0);

        // Single frame L=1, R=0x800000.
        do_reset();
        cs_tb = 32'h0;
        enable = 1'b1;
        push_pair(24'h000001, 24'h800000, 5);
        run_ticks(1);
        enable = 1'b0;
        run_ticks(200);
        chk("single_nsub", n_sub, 2);
        chk("single_L_bit4", {31'd0, last_wl[4]}, 32'd1);
        chk("single_L_par", {31'd0, last_wl[31]}, 32'd1);
        chk("single_R_bit27", {31'd0, last_wr[27]}, 32'd1);
        chk("single_R_par", {31'd0, last_wr[31]}, 32'd1);
        chk("single_line_idle", {31'd0, spdif_o}, 32'd0);
        chk("single_sb_left", sb_q.size(), 0);

        // Block structure over 200 frames with channel status bit 2 set.
        do_reset();
        cs_tb = 32'h0000_0004;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) push_pair(24'($urandom), 24'($urandom), 5);
        fork
            run_ticks(25500);
            for (int i = 0; i < 196; i++) push_pair(24'($urandom), 24'($urandom), 2000);
        join
        enable = 1'b0;
        run_ticks(200);
        chk("block_nsub", n_sub, 400);
        chk("block_bs_total", bs_total, 2);
        chk("block_sb_left", sb_q.size(), 0);
        cs_tb = 32'h0;

        // Underrun: three pairs, two starved frames, then a resumed pair.
        do_reset();
        enable = 1'b1;
        push_pair(24'h123456, 24'h654321, 5);
        push_pair(24'hABCDEF, 24'h0F0F0F, 5);
        push_pair(24'h7FFFFF, 24'h800001, 5);
        push_underrun();
        push_underrun();
        run_ticks(640);
        push_pair(24'h00FF00, 24'hFF00FF, 5);
        run_ticks(2);
        enable = 1'b0;
        run_ticks(200);
        chk("ur_nsub", n_sub, 12);
        chk("ur_total", ur_total, 2);
        chk("ur_sb_left", sb_q.size(), 0);

        // Backpressure: four fill the FIFO, the fifth waits for the first pop.
        do_reset();
        for (int i = 0; i < 4; i++) push_pair(24'(32'h111111 * (i + 1)), 24'(32'h010101 * (i + 1)), 5);
        chk("bp_ready_full", {31'd0, sample_ready_o}, 32'd0);
        @(negedge clk);
        sample_l = 24'hC0FFEE;
        sample_r = 24'hBADF00;
        sample_valid = 1'b1;
        hold_hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (sample_ready_o) hold_hi++;
        end
        chk("bp_hold", hold_hi, 0);
        enable = 1'b1;
        tick();
        chk("bp_ready_after_pop", {31'd0, sample_ready_o}, 32'd1);
        @(negedge clk);
        sample_valid = 1'b0;
        begin
            exp_t e5;
            e5.l = 24'hC0FFEE; e5.r = 24'hBADF00; e5.v = 1'b0;
            sb_q.push_back(e5);
        end
        run_ticks(4 * 128 + 2);
        enable = 1'b0;
        run_ticks(200);
        chk("bp_nsub", n_sub, 10);
        chk("bp_sb_left", sb_q.size(), 0);

        // Disruptions: enable drop mid-L, async reset mid-subframe, restart with Z.
        do_reset();
        enable = 1'b1;
        push_pair(24'h0A0A0A, 24'h050505, 5);
        push_pair(24'h3C3C3C, 24'hC3C3C3, 5);
        run_ticks(22);
        enable = 1'b0;
        run_ticks(250);
        chk("dis_nsub", n_sub, 2);
        chk("dis_sb_left", sb_q.size(), 1);
        chk("dis_line_idle", {31'd0, spdif_o}, 32'd0);
        push_pair(24'h999999, 24'h666666, 5);
        enable = 1'b1;
        run_ticks(30);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("arst_spdif", {31'd0, spdif_o}, 32'd0);
        chk("arst_ready", {31'd0, sample_ready_o}, 32'd1);
        chk("arst_block_start", {31'd0, block_start_o}, 32'd0);
        chk("arst_underrun", {31'd0, underrun_o}, 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("arst_ready_after", {31'd0, sample_ready_o}, 32'd1);
        push_underrun();
        run_ticks(2);
        enable = 1'b0;
        run_ticks(200);
        chk("restart_nsub", n_sub, 2);
        chk("restart_ur_total", ur_total, 1);
        chk("restart_sb_left", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
